if_fetch_ctrl: RTL and testbench

- Instruction-fetch controller directly downstream of the PC stage.
- Takes pc/ce from the PC register and issues one request at a time to the instruction memory over a req/ack handshake.
- Delivers {pc, inst, valid} into the IF/ID slot consumed by decode.
- Holds the PC stage via stall_req_o while a fetch is outstanding, and kills wrong-path fetches on branch_flag_i.

---
 rtl/if_fetch_ctrl_pkg.sv | 18 +
 rtl/if_fetch_ctrl_skid.sv | 35 +++
 rtl/if_fetch_ctrl.sv | 134 +++++++++++++
 tb/tb_if_fetch_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared fetch-controller definitions: FSM encodings and bus widths.
// Imported by the IF fetch controller and its slot registers.
package if_fetch_ctrl_pkg;

  localparam logic RstEnable  = 1'b1;
  localparam logic ChipEnable = 1'b1;
  localparam logic Branch     = 1'b1;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_BUSY = 2'b01,
    FETCH_FULL = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl_skid.sv
// One-entry {pc, inst, valid} register with load and clear.
// Serves both as the skid buffer and as the IF/ID output slot.
module if_skid_reg
  import if_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int INST_W = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] pc_d,
  input  logic [INST_W-1:0] inst_d,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst,
  output logic              valid
);

  // clear only drops valid; payload is kept so consumers see stable data
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc    <= '0;
      inst  <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_d;
      inst  <= inst_d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: one outstanding req/ack fetch,
// PC-stage hold, wrong-path kill and a skid slot toward decode.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int INST_W = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              branch_flag_i,
  input  logic              id_stall_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [INST_W-1:0] mem_data_i,
  output logic              stall_req_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic              if_valid_o
);

  fetch_state_t state;
  logic         kill;

  logic              br;
  logic              slot_free;
  logic              ack_live;
  logic              busy_dlv;
  logic              full_dlv;
  logic              out_load;
  logic              out_clear;
  logic              skid_load;
  logic              skid_clear;
  logic [ADDR_W-1:0] out_pc_d;
  logic [INST_W-1:0] out_inst_d;
  logic [ADDR_W-1:0] skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic              skid_valid;

  assign br          = (branch_flag_i == Branch);
  assign stall_req_o = (state != FETCH_IDLE);
  assign slot_free   = !if_valid_o || !id_stall_i;

  // an ack is only usable if nothing younger than a branch is in flight
  assign ack_live = (state == FETCH_BUSY) && mem_ack_i
                  && !kill && !br;

  assign busy_dlv  = ack_live && slot_free;
  assign skid_load = ack_live && !slot_free;
  assign full_dlv  = skid_valid && !br && !id_stall_i;

  assign out_load   = busy_dlv || full_dlv;
  assign out_clear  = br || (!id_stall_i && !out_load);
  assign skid_clear = skid_valid && (br || !id_stall_i);

  assign out_pc_d   = busy_dlv ? mem_addr_o : skid_pc;
  assign out_inst_d = busy_dlv ? mem_data_i : skid_inst;

  if_skid_reg #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .clear  (skid_clear),
    .pc_d   (mem_addr_o),
    .inst_d (mem_data_i),
    .pc     (skid_pc),
    .inst   (skid_inst),
    .valid  (skid_valid)
  );

  if_skid_reg #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_slot (
    .clk    (clk),
    .rst    (rst),
    .load   (out_load),
    .clear  (out_clear),
    .pc_d   (out_pc_d),
    .inst_d (out_inst_d),
    .pc     (if_pc_o),
    .inst   (if_inst_o),
    .valid  (if_valid_o)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state      <= FETCH_IDLE;
      kill       <= 1'b0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (ce_i == ChipEnable && !br) begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= pc_i;
            state      <= FETCH_BUSY;
          end
        end
        FETCH_BUSY: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            kill      <= 1'b0;
            if (kill || br || slot_free) begin
              state <= FETCH_IDLE;
            end else begin
              state <= FETCH_FULL;
            end
          end else if (br) begin
            kill <= 1'b1;
          end
        end
        FETCH_FULL: begin
          if (br || !id_stall_i) begin
            state <= FETCH_IDLE;
          end
        end
        default: begin
          state     <= FETCH_IDLE;
          mem_req_o <= 1'b0;
          kill      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: PC-stage and memory models,
// delivery scoreboard and immediate-assertion checks.
module tb_if_fetch_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic        branch;
  logic [31:0] tgt;
  logic        id_stall;
  logic        pc_set;
  logic [31:0] pc_set_val;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        stall_req;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  logic        auto_en;
  logic        auto_ack;
  logic [31:0] auto_data;
  logic        man_ack;
  logic [31:0] man_data;
  int          ack_lat;
  int          wait_cnt;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_t;
  logic eq_en;
  logic gap_en;
  exp_t sb[$];

  assign mem_ack  = auto_ack | man_ack;
  assign mem_data = man_ack ? man_data : auto_data;

  if_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc),
    .ce_i          (ce),
    .branch_flag_i (branch),
    .id_stall_i    (id_stall),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_ack_i     (mem_ack),
    .mem_data_i    (mem_data),
    .stall_req_o   (stall_req),
    .if_pc_o       (if_pc),
    .if_inst_o     (if_inst),
    .if_valid_o    (if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc   = a;
    e.inst = memval(a);
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(input logic [31:0] a);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req && mem_addr == a) && n < 50);
    chk("issue", {31'b0, mem_req, mem_addr}, {31'b0, 1'b1, a});
  endtask

  task automatic set_pc(input logic [31:0] a);
    step();
    pc_set     = 1'b1;
    pc_set_val = a;
    step();
    pc_set     = 1'b0;
  endtask

  // PC stage: advances only when the fetch controller is not holding it
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst)
      pc <= 32'h0;
    else if (pc_set)
      pc <= pc_set_val;
    else if (branch)
      pc <= tgt;
    else if (ce && !stall_req)
      pc <= pc + 32'h4;
  end

  initial begin
    auto_ack  = 1'b0;
    auto_data = 32'h0;
    wait_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      auto_ack = 1'b0;
      if (auto_en && !rst && mem_req) begin
        if (wait_cnt >= ack_lat) begin
          auto_ack  = 1'b1;
          auto_data = memval(mem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if_valid && !id_stall && !branch) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", {32'b0, if_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dlv_pc", {32'b0, if_pc}, {32'b0, e.pc});
        chk("dlv_inst", {32'b0, if_inst}, {32'b0, e.inst});
      end
      if (gap_en) begin
        if (last_t >= 0) chk("gap", 64'(cyc - last_t), 64'd2);
        last_t = cyc;
      end
    end
    if (eq_en) chk("stall_busy", {63'b0, stall_req}, {63'b0, mem_req});
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; ce = 1'b0; branch = 1'b0; tgt = 32'h0;
    id_stall = 1'b0; pc_set = 1'b0; pc_set_val = 32'h0;
    auto_en = 1'b1; man_ack = 1'b0; man_data = 32'h0;
    ack_lat = 0; eq_en = 1'b0; gap_en = 1'b0; last_t = -1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {63'b0, mem_req}, 64'd0);
    chk("rst_addr", {32'b0, mem_addr}, 64'd0);
    chk("rst_valid", {63'b0, if_valid}, 64'd0);
    chk("rst_pc", {32'b0, if_pc}, 64'd0);
    chk("rst_inst", {32'b0, if_inst}, 64'd0);
    chk("rst_stall", {63'b0, stall_req}, 64'd0);

    // back-to-back fetch, ack one cycle after request
    push(32'h0); push(32'h4); push(32'h8);
    step();
    rst = 1'b0; ce = 1'b1; eq_en = 1'b1; gap_en = 1'b1;
    wait_issue(32'h0);
    wait_issue(32'h4);
    wait_issue(32'h8);
    ce = 1'b0;
    repeat (4) @(negedge clk);
    eq_en = 1'b0; gap_en = 1'b0;
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // slow memory
    ack_lat = 2;
    set_pc(32'h10);
    push(32'h10);
    ce = 1'b1;
    wait_issue(32'h10);
    ce = 1'b0;
    n = 0;
    while (mem_req && n < 20) begin
      chk("t2_addr", {32'b0, mem_addr}, 64'h10);
      chk("t2_stall", {63'b0, stall_req}, 64'd1);
      n++;
      @(negedge clk);
    end
    chk("t2_req_cycles", 64'(n), 64'd3);
    repeat (3) @(negedge clk);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);

    // decode stalled with slot valid: second fetch lands in skid
    ack_lat = 0;
    step();
    id_stall = 1'b1;
    set_pc(32'h20);
    push(32'h20); push(32'h24);
    ce = 1'b1;
    wait_issue(32'h24);
    ce = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t3_full_stall", {63'b0, stall_req}, 64'd1);
    chk("t3_full_req", {63'b0, mem_req}, 64'd0);
    chk("t3_hold_pc", {32'b0, if_pc}, 64'h20);
    chk("t3_hold_valid", {63'b0, if_valid}, 64'd1);
    step();
    id_stall = 1'b0;
    ce = 1'b1;
    @(negedge clk);
    chk("t3_still_pc", {32'b0, if_pc}, 64'h20);
    @(negedge clk);
    chk("t3_skid_pc", {32'b0, if_pc}, 64'h24);
    chk("t3_skid_valid", {63'b0, if_valid}, 64'd1);
    chk("t3_idle", {63'b0, stall_req}, 64'd0);
    push(32'h28);
    wait_issue(32'h28);
    ce = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);

    // branch while busy: in-flight fetch is killed
    ack_lat = 2;
    set_pc(32'h30);
    push(32'h100);
    ce = 1'b1;
    wait_issue(32'h30);
    step();
    branch = 1'b1;
    tgt    = 32'h100;
    step();
    branch = 1'b0;
    @(negedge clk);
    chk("t4_busy", {63'b0, mem_req}, 64'd1);
    @(negedge clk);
    chk("t4_discard_valid", {63'b0, if_valid}, 64'd0);
    chk("t4_discard_req", {63'b0, mem_req}, 64'd0);
    wait_issue(32'h100);
    ce = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    // branch coincident with ack while decode stalled
    ack_lat = 0;
    step();
    id_stall = 1'b1;
    set_pc(32'h200);
    ce = 1'b1;
    wait_issue(32'h204);
    #1;
    branch = 1'b1;
    tgt    = 32'h300;
    ce     = 1'b0;
    step();
    branch = 1'b0;
    @(negedge clk);
    chk("t5_valid", {63'b0, if_valid}, 64'd0);
    chk("t5_idle", {63'b0, stall_req}, 64'd0);
    chk("t5_req", {63'b0, mem_req}, 64'd0);
    step();
    id_stall = 1'b0;
    @(negedge clk);
    chk("t5_no_full", {63'b0, stall_req}, 64'd0);
    chk("t5_valid2", {63'b0, if_valid}, 64'd0);

    // reset while busy, then a stray ack
    auto_en = 1'b0;
    set_pc(32'h400);
    ce = 1'b1;
    wait_issue(32'h400);
    ce = 1'b0;
    step();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_req", {63'b0, mem_req}, 64'd0);
    chk("t6_addr", {32'b0, mem_addr}, 64'd0);
    chk("t6_valid", {63'b0, if_valid}, 64'd0);
    chk("t6_stall", {63'b0, stall_req}, 64'd0);
    step();
    rst      = 1'b0;
    man_ack  = 1'b1;
    man_data = 32'hBAD0_BAD0;
    step();
    man_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_late_valid", {63'b0, if_valid}, 64'd0);
      chk("t6_late_stall", {63'b0, stall_req}, 64'd0);
    end
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
